// File: rtl/reg_writeback_queue_pkg.sv
`default_nettype none
// =============================================================================
// reg_writeback_queue_pkg : shared register write-request types and widths
// Rev 1.0
// =============================================================================
package reg_writeback_queue_pkg;

  localparam int DATA_W   = 16;
  localparam int SEL_W    = 3;
  localparam int NUM_REGS = 8;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/reg_writeback_queue_wb_fifo.sv
`default_nettype none
// =============================================================================
// wb_fifo : in-order write-request FIFO exposing its entries in age order
// Rev 1.0
// =============================================================================
module wb_fifo
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_req_t                  push_data,
  input  logic                     pop,
  output wb_req_t                  head,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output wb_req_t [DEPTH-1:0]      age_entry,
  output logic [DEPTH-1:0]         age_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count_q != '0);
  assign count   = count_q;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Index 0 is the head (oldest); higher indices are progressively younger.
  always_comb begin
    age_entry = '0;
    age_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_entry[i] = mem[rd_ptr + PTR_W'(i)];
      age_valid[i] = (CNT_W'(i) < count_q);
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_writeback_queue.sv
`default_nettype none
// =============================================================================
// reg_writeback_queue : buffered register-file write port with hazard lookup
// Rev 1.0
// =============================================================================
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = reg_writeback_queue_pkg::DATA_W,
  parameter int SEL_W  = reg_writeback_queue_pkg::SEL_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [SEL_W-1:0]       req_sel,
  input  logic [DATA_W-1:0]      req_data,
  output logic                   wr_en,
  output logic [SEL_W-1:0]       wr_sel,
  output logic [DATA_W-1:0]      wr_data,
  input  logic                   wr_stall,
  input  logic [SEL_W-1:0]       chk_sel,
  output logic                   chk_hit,
  output logic [DATA_W-1:0]      chk_data,
  output logic [$clog2(DEPTH):0] count
);

  reg_writeback_queue_pkg::wb_req_t                push_ent;
  reg_writeback_queue_pkg::wb_req_t                head;
  reg_writeback_queue_pkg::wb_req_t [DEPTH-1:0]    age_entry;
  logic [DEPTH-1:0]                                age_valid;
  logic                                            full;
  logic                                            push;
  logic                                            pop;

  assign push_ent.sel  = req_sel;
  assign push_ent.data = req_data;
  assign req_ready     = !full;
  assign push          = req_valid && req_ready;
  assign pop           = !(wr_en && wr_stall) && (count != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_ent),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .count     (count),
    .age_entry (age_entry),
    .age_valid (age_valid)
  );

  // A stalled write holds; otherwise the head moves into the output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_sel  <= '0;
      wr_data <= '0;
    end else if (wr_en && wr_stall) begin
      wr_en   <= wr_en;
    end else if (pop) begin
      wr_en   <= 1'b1;
      wr_sel  <= head.sel;
      wr_data <= head.data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  // Output stage is oldest, so it is considered first and overridden by younger FIFO matches.
  always_comb begin
    chk_hit  = 1'b0;
    chk_data = '0;
    if (wr_en && (wr_sel == chk_sel)) begin
      chk_hit  = 1'b1;
      chk_data = wr_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (age_valid[i] && (age_entry[i].sel == chk_sel)) begin
        chk_hit  = 1'b1;
        chk_data = age_entry[i].data;
      end
    end
  end

endmodule
`default_nettype wire
